// File: rtl/rle_serial_rx_decoder_pkg.sv
// Shared definitions for the run-length serial link (receive side).
//   - line levels and frame geometry
//   - deserializer and emitter state encodings
//   - byte-layout helpers shared with the encoder: bit0 = colour,
//     bits 7:1 = run length, 0x00 = end-of-line token
package rle_serial_rx_decoder_pkg;

  localparam logic       MARKING      = 1'b1;
  localparam logic       SPACING      = 1'b0;
  localparam logic [7:0] ENDLINE_CODE = 8'h00;
  localparam int         FRAME_BITS   = 10;   // start + 8 data + stop
  localparam int         DATA_BITS    = 8;

  typedef enum logic [1:0] {
    DES_ARM  = 2'd0,
    DES_HUNT = 2'd1,
    DES_DATA = 2'd2,
    DES_STOP = 2'd3
  } des_state_t;

  typedef enum logic [1:0] {
    EMIT_IDLE    = 2'd0,
    EMIT_PRESENT = 2'd1,
    EMIT_RELEASE = 2'd2
  } emit_state_t;

  function automatic logic byte_colour(input logic [7:0] b);
    return b[0];
  endfunction

  function automatic logic [6:0] byte_run(input logic [7:0] b);
    return b[7:1];
  endfunction

endpackage

// File: rtl/rle_serial_rx_decoder_if.sv
// Pins of the run-length serial receiver.
//   rxd        serial line in, idle marking
//   rfd        consumer ready-for-data
//   colore     pixel colour, valid while dav_ = 0
//   endline    handshake carries an end-of-line token
//   dav_       data valid, active low
//   overrun    sticky: byte dropped on a full buffer
//   frame_err  sticky: stop bit sampled as spacing
//   des_state  deserializer state (observation only)
//   emit_state emitter state (observation only)
// Handshake (4-phase): the decoder drives dav_ low with colore/endline
// stable only while rfd is high; the consumer then drops rfd; the decoder
// raises dav_; the consumer raises rfd again, completing one transfer.
interface rle_serial_rx_decoder_if;
  import rle_serial_rx_decoder_pkg::*;

  logic        rxd;
  logic        rfd;
  logic        colore;
  logic        endline;
  logic        dav_;
  logic        overrun;
  logic        frame_err;
  des_state_t  des_state;
  emit_state_t emit_state;

  modport master (
    input  rxd, rfd,
    output colore, endline, dav_, overrun, frame_err, des_state, emit_state
  );

  modport slave (
    output rxd, rfd,
    input  colore, endline, dav_, overrun, frame_err, des_state, emit_state
  );

endinterface

// File: rtl/rle_byte_fifo.sv
// Small first-word-fall-through byte buffer.
//   clock, reset  system clock, async active-high reset
//   push, wdata   write request and data (ignored when full unless popping)
//   pop           read request (head advances; ignored when empty)
//   rdata         current head entry
//   full, empty   occupancy flags
// A push and pop on the same edge while full is accepted: the slot being
// vacated is the one written.
module rle_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rle_serial_rx_decoder.sv
// Run-length serial receiver. Deserializes 10-bit frames (start spacing,
// 8 data bits LSB first, stop marking) sampled once per clock, buffers the
// decoded bytes and replays them as pixels on a 4-phase colore/endline/
// dav_/rfd handshake: one dav_ low pulse per pixel, one per end-of-line.
//   clock  system clock
//   reset  asynchronous active-high reset
//   bus    rle_serial_rx_decoder_if.master (rxd, rfd in; pixel outputs,
//          sticky flags and state observation out)
module rle_serial_rx_decoder
  import rle_serial_rx_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RUN_W      = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  rle_serial_rx_decoder_if.master       bus
);

  // ---------------- deserializer ----------------
  des_state_t des_state;
  logic [7:0] sreg;
  logic [2:0] bitcnt;
  logic       frame_err_q;
  logic       overrun_q;

  // ---------------- buffer ----------------
  logic       push;
  logic       pop;
  logic [7:0] head;
  logic       fifo_full;
  logic       fifo_empty;

  // ---------------- emitter ----------------
  emit_state_t      emit_state;
  logic [RUN_W-1:0] rem;
  logic             colore_q;
  logic             endline_q;
  logic             dav_q;

  // The byte is pushed on the same edge that samples a good stop bit.
  assign push = (des_state == DES_STOP) && (bus.rxd == MARKING);

  // Pop from IDLE, or straight from RELEASE once the current run is spent,
  // so consecutive runs follow with no idle cycle.
  assign pop = !fifo_empty && bus.rfd &&
               ((emit_state == EMIT_IDLE) ||
                (emit_state == EMIT_RELEASE && rem == '0));

  rle_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (sreg),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      des_state   <= DES_ARM;
      sreg        <= '0;
      bitcnt      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      case (des_state)
        // One marking sample is needed before a start bit is believed, so a
        // line caught mid-frame cannot fake a start.
        DES_ARM: begin
          if (bus.rxd == MARKING) des_state <= DES_HUNT;
        end
        DES_HUNT: begin
          if (bus.rxd == SPACING) begin
            bitcnt    <= '0;
            des_state <= DES_DATA;
          end
        end
        DES_DATA: begin
          sreg   <= {bus.rxd, sreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'(DATA_BITS - 1)) des_state <= DES_STOP;
        end
        DES_STOP: begin
          if (bus.rxd == MARKING) begin
            des_state <= DES_HUNT;
          end else begin
            frame_err_q <= 1'b1;
            des_state   <= DES_ARM;
          end
        end
        default: des_state <= DES_ARM;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      emit_state <= EMIT_IDLE;
      rem        <= '0;
      colore_q   <= 1'b0;
      endline_q  <= 1'b0;
      dav_q      <= 1'b1;
    end else if (pop) begin
      if (head == ENDLINE_CODE) begin
        endline_q  <= 1'b1;
        rem        <= '0;
        dav_q      <= 1'b0;
        emit_state <= EMIT_PRESENT;
      end else if (byte_run(head) == '0) begin
        // Zero-length run: consumed without any handshake.
        emit_state <= EMIT_IDLE;
      end else begin
        colore_q   <= byte_colour(head);
        endline_q  <= 1'b0;
        rem        <= RUN_W'(byte_run(head)) - RUN_W'(1);
        dav_q      <= 1'b0;
        emit_state <= EMIT_PRESENT;
      end
    end else begin
      case (emit_state)
        EMIT_IDLE: ;
        EMIT_PRESENT: begin
          if (!bus.rfd) begin
            dav_q      <= 1'b1;
            emit_state <= EMIT_RELEASE;
          end
        end
        EMIT_RELEASE: begin
          if (bus.rfd) begin
            // rem == 0 with data waiting is handled by the pop branch.
            if (rem != '0) begin
              rem        <= rem - RUN_W'(1);
              dav_q      <= 1'b0;
              emit_state <= EMIT_PRESENT;
            end else begin
              emit_state <= EMIT_IDLE;
            end
          end
        end
        default: emit_state <= EMIT_IDLE;
      endcase
    end
  end

  assign bus.colore     = colore_q;
  assign bus.endline    = endline_q;
  assign bus.dav_       = dav_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.des_state  = des_state;
  assign bus.emit_state = emit_state;

endmodule

// File: tb/tb_rle_serial_rx_decoder.sv
// Bench for rle_serial_rx_decoder: frame driver, echoing consumer,
// handshake monitor with an expected-pixel queue, scenario tasks.
module tb_rle_serial_rx_decoder;
  import rle_serial_rx_decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rle_serial_rx_decoder_if bus();

  rle_serial_rx_decoder #(
    .FIFO_DEPTH (4),
    .RUN_W      (7)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // expected pixel: {endline, colore}; colore ignored for endline tokens
  logic [1:0] exp_q[$];

  // ---------------- consumer ----------------
  // With rfd_auto the consumer follows dav_ one clock later (4-phase echo).
  bit   rfd_auto = 1'b1;
  logic rfd_hold = 1'b1;
  always @(posedge clock) begin
    #1;
    bus.rfd = rfd_auto ? bus.dav_ : rfd_hold;
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prev_dav = 1'b1;
  logic [1:0] held = 2'b00;
  logic [1:0] exp_px;
  int         cyc = 0;
  int         last_fall = -1;
  int         pix_cnt = 0;
  int         gaps[$];

  always @(negedge clock) begin
    cyc++;
    if (reset !== 1'b1) begin
      if (prev_dav === 1'b1 && bus.dav_ === 1'b0) begin
        pix_cnt++;
        if (last_fall >= 0) gaps.push_back(cyc - last_fall);
        last_fall = cyc;
        held = {bus.endline, bus.colore};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_handshake endline=%b colore=%b required none", bus.endline, bus.colore);
        end else begin
          exp_px = exp_q.pop_front();
          if (bus.endline !== exp_px[1] || (exp_px[1] == 1'b0 && bus.colore !== exp_px[0])) begin
            errors++;
            $display("FAIL pixel got endline=%b colore=%b required endline=%b colore=%b",
                     bus.endline, bus.colore, exp_px[1], exp_px[0]);
          end
        end
      end else if (prev_dav === 1'b0 && bus.dav_ === 1'b0) begin
        checks++;
        if ({bus.endline, bus.colore} !== held) begin
          errors++;
          $display("FAIL hold_while_valid got %b required %b", {bus.endline, bus.colore}, held);
        end
      end
    end
    prev_dav = bus.dav_;
  end

  // ---------------- drivers ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_out);
    logic [FRAME_BITS-1:0] f;
    f = {stop_bit, b, SPACING};
    if (expect_out && stop_bit == MARKING) begin
      if (b == 8'h00) exp_q.push_back(2'b10);
      else for (int n = 0; n < int'(b[7:1]); n++) exp_q.push_back({1'b0, b[0]});
    end
    for (int i = 0; i < FRAME_BITS; i++) begin
      @(negedge clock);
      bus.rxd = f[i];
    end
  endtask

  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && bus.dav_ === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (8) @(negedge clock);
    bus.rxd = MARKING;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset   = 1'b1;
    bus.rxd = MARKING;
    repeat (3) @(negedge clock);
    checks++; if (bus.dav_ !== 1'b1)       begin errors++; $display("FAIL rst_dav got %b required 1", bus.dav_); end
    checks++; if (bus.colore !== 1'b0)     begin errors++; $display("FAIL rst_colore got %b required 0", bus.colore); end
    checks++; if (bus.endline !== 1'b0)    begin errors++; $display("FAIL rst_endline got %b required 0", bus.endline); end
    checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL rst_overrun got %b required 0", bus.overrun); end
    checks++; if (bus.frame_err !== 1'b0)  begin errors++; $display("FAIL rst_frame_err got %b required 0", bus.frame_err); end
    checks++; if (bus.des_state !== DES_ARM)    begin errors++; $display("FAIL rst_des_state got %0d required %0d", bus.des_state, DES_ARM); end
    checks++; if (bus.emit_state !== EMIT_IDLE) begin errors++; $display("FAIL rst_emit_state got %0d required %0d", bus.emit_state, EMIT_IDLE); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_run();
    bit ok;
    int p0;
    p0 = pix_cnt;
    send_frame(8'h07, MARKING, 1'b1);
    // stop bit sampled on the next edge; dav_ must fall one edge later
    @(negedge clock);
    bus.rxd = MARKING;
    checks++; if (bus.dav_ !== 1'b1) begin errors++; $display("FAIL latency_early dav_ got %b required 1", bus.dav_); end
    @(negedge clock);
    checks++; if (bus.dav_ !== 1'b0) begin errors++; $display("FAIL latency_fall dav_ got %b required 0", bus.dav_); end
    wait_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain timeout left=%0d required 0", exp_q.size()); end
    checks++; if (pix_cnt - p0 != 3) begin errors++; $display("FAIL single_count got %0d required 3", pix_cnt - p0); end
    checks++; if (bus.emit_state !== EMIT_IDLE) begin errors++; $display("FAIL single_idle got %0d required %0d", bus.emit_state, EMIT_IDLE); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int g0;
    int p0;
    p0 = pix_cnt;
    g0 = gaps.size();
    send_frame(8'h0A, MARKING, 1'b1);
    send_frame(8'h00, MARKING, 1'b1);
    wait_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain timeout left=%0d required 0", exp_q.size()); end
    checks++; if (pix_cnt - p0 != 6) begin errors++; $display("FAIL b2b_count got %0d required 6", pix_cnt - p0); end
    // first new gap spans from the previous test; the next five must be tight
    for (int i = g0 + 1; i < g0 + 6 && i < gaps.size(); i++) begin
      checks++;
      if (gaps[i] != 2) begin errors++; $display("FAIL b2b_gap idx=%0d got %0d cycles required 2", i - g0, gaps[i]); end
    end
  endtask

  task automatic test_frame_err();
    bit ok;
    int p0;
    p0 = pix_cnt;
    send_frame(8'h05, SPACING, 1'b0);
    @(negedge clock);
    bus.rxd = MARKING;
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL frame_err got %b required 1", bus.frame_err); end
    checks++; if (bus.des_state !== DES_ARM) begin errors++; $display("FAIL ferr_arm got %0d required %0d", bus.des_state, DES_ARM); end
    send_frame(8'h05, MARKING, 1'b1);
    wait_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ferr_drain timeout left=%0d required 0", exp_q.size()); end
    checks++; if (pix_cnt - p0 != 2) begin errors++; $display("FAIL ferr_count got %0d required 2", pix_cnt - p0); end
  endtask

  task automatic test_overrun();
    bit ok;
    int p0;
    p0 = pix_cnt;
    rfd_auto = 1'b0;
    rfd_hold = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) send_frame(8'h03, MARKING, 1'b1);
    @(negedge clock);
    bus.rxd = MARKING;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_early got %b required 0", bus.overrun); end
    send_frame(8'h03, MARKING, 1'b0);
    @(negedge clock);
    bus.rxd = MARKING;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b required 1", bus.overrun); end
    checks++; if (pix_cnt != p0) begin errors++; $display("FAIL overrun_stalled got %0d pixels required 0", pix_cnt - p0); end
    rfd_auto = 1'b1;
    wait_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL overrun_drain timeout left=%0d required 0", exp_q.size()); end
    checks++; if (pix_cnt - p0 != 4) begin errors++; $display("FAIL overrun_count got %0d required 4", pix_cnt - p0); end
  endtask

  task automatic test_long_and_zero_run();
    bit ok;
    int p0;
    p0 = pix_cnt;
    send_frame(8'hFF, MARKING, 1'b1);
    wait_drain(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL long_drain timeout left=%0d required 0", exp_q.size()); end
    checks++; if (pix_cnt - p0 != 127) begin errors++; $display("FAIL long_count got %0d required 127", pix_cnt - p0); end
    p0 = pix_cnt;
    send_frame(8'h01, MARKING, 1'b1);
    wait_drain(100, ok);
    checks++; if (pix_cnt != p0) begin errors++; $display("FAIL zero_run got %0d pixels required 0", pix_cnt - p0); end
    checks++; if (bus.emit_state !== EMIT_IDLE) begin errors++; $display("FAIL zero_run_idle got %0d required %0d", bus.emit_state, EMIT_IDLE); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int p0;
    // reset in the middle of a frame's data bits
    @(negedge clock); bus.rxd = SPACING;
    for (int i = 0; i < 3; i++) begin @(negedge clock); bus.rxd = i[0]; end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.des_state !== DES_ARM) begin errors++; $display("FAIL mid_data_state got %0d required %0d", bus.des_state, DES_ARM); end
    checks++; if (bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL mid_data_flags got overrun=%b frame_err=%b required 0 0", bus.overrun, bus.frame_err);
    end
    @(negedge clock); bus.rxd = MARKING;
    @(negedge clock); reset = 1'b0;
    // reset in the middle of a long run
    send_frame(8'hFF, MARKING, 1'b1);
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    checks++; if (bus.dav_ !== 1'b1)    begin errors++; $display("FAIL mid_run_dav got %b required 1", bus.dav_); end
    checks++; if (bus.colore !== 1'b0)  begin errors++; $display("FAIL mid_run_colore got %b required 0", bus.colore); end
    checks++; if (bus.endline !== 1'b0) begin errors++; $display("FAIL mid_run_endline got %b required 0", bus.endline); end
    checks++; if (bus.emit_state !== EMIT_IDLE) begin errors++; $display("FAIL mid_run_state got %0d required %0d", bus.emit_state, EMIT_IDLE); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    p0 = pix_cnt;
    send_frame(8'h07, MARKING, 1'b1);
    wait_drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_reset_drain timeout left=%0d required 0", exp_q.size()); end
    checks++; if (pix_cnt - p0 != 3) begin errors++; $display("FAIL post_reset_count got %0d required 3", pix_cnt - p0); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_long_and_zero_run();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
